// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants, fetch FSM state type and PC helper for the fetch stage.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'hE1A0_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  // Next sequential word address; wraps naturally at 2^32.
  function automatic logic [31:0] pc_next_word(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle for the fetch stage: instruction memory, redirect and decoder handshake.
interface instruction_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        redirect_en;
  logic [31:0] redirect_pc;

  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus8;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_en, redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instruction, instr_pc, instr_pc_plus8
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_en, redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instruction, instr_pc, instr_pc_plus8
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Prefetch FIFO of {pc, instruction} pairs with flush; flush wins over push/pop.
module fetch_buffer #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [31:0]   i_pc,
  input  logic [31:0]   i_instr,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [31:0]   o_pc,
  output logic [31:0]   o_instr,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_pc      = r_pc_mem[r_rd_ptr];
  assign o_instr   = r_instr_mem[r_rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_pc_mem[r_wr_ptr]    <= i_pc;
      r_instr_mem[r_wr_ptr] <= i_instr;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: fetch PC, single-outstanding imem read FSM, prefetch buffer, decoder output.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_VECTOR,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic                       clk,
  input logic                       rst,
  instruction_fetch_unit_if.master  bus
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  fetch_state_e  r_state;
  fetch_state_e  w_state_next;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_next;
  logic [31:0]   r_addr;
  logic [31:0]   w_addr_next;
  logic [31:0]   w_redirect_target;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic          w_outstanding;
  logic          w_space;
  logic          w_space_after_push;
  logic [31:0]   w_head_pc;
  logic [31:0]   w_head_instr;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pc    (r_fetch_pc),
    .i_instr (bus.imem_rdata),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_en),
    .o_pc    (w_head_pc),
    .o_instr (w_head_instr),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign w_redirect_target  = bus.redirect_pc & 32'hFFFF_FFFC;
  assign w_valid            = !w_empty;
  assign w_pop              = w_valid && bus.instr_ready && !bus.redirect_en;
  assign w_outstanding      = (r_state == ST_WAIT);
  // Space uses the registered count only: a same-cycle pop frees nothing yet.
  assign w_space            = !w_full && ((32'(w_count) + 32'(w_outstanding)) < BUF_DEPTH);
  assign w_space_after_push = (32'(w_count) + 32'd1) < BUF_DEPTH;

  // Next-state, next fetch PC, request address and push decision.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_addr_next     = r_addr;
    w_push          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.redirect_en) begin
          w_fetch_pc_next = w_redirect_target;
          w_addr_next     = w_redirect_target;
          w_state_next    = ST_WAIT;
        end else if (w_space) begin
          w_addr_next  = r_fetch_pc;
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.redirect_en) begin
          w_fetch_pc_next = w_redirect_target;
          w_state_next    = bus.imem_ack ? ST_IDLE : ST_DISCARD;
        end else if (bus.imem_ack) begin
          w_push          = 1'b1;
          w_fetch_pc_next = pc_next_word(r_fetch_pc);
          if (w_space_after_push) begin
            w_addr_next = pc_next_word(r_fetch_pc);
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (bus.redirect_en) begin
          w_fetch_pc_next = w_redirect_target;
        end
        // Buffer is empty here (flushed on entry), so the target issues at once.
        if (bus.imem_ack) begin
          w_addr_next  = bus.redirect_en ? w_redirect_target : r_fetch_pc;
          w_state_next = ST_WAIT;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state, fetch PC and held request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_addr     <= w_addr_next;
    end
  end

  assign bus.imem_req       = (r_state != ST_IDLE);
  assign bus.imem_addr      = r_addr;
  assign bus.instr_valid    = w_valid;
  assign bus.instruction    = w_valid ? w_head_instr : NOP_INSTR;
  assign bus.instr_pc       = w_valid ? w_head_pc : '0;
  assign bus.instr_pc_plus8 = bus.instr_pc + 32'd8;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a queue scoreboard and memory responder.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus8;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [31:0] addr_log[$];
  int          lat    = 1;
  bit          mem_on = 1'b1;
  bit          stray  = 1'b0;
  int          mem_cnt;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < addr_log.size()) return addr_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] plus8);
    exp_t e;
    e.pc    = pc;
    e.plus8 = plus8;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    bus.instr_ready = 1'b0;
    check({name, " drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    addr_log.delete();
    rst = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = pc;
    tick(1);
    bus.redirect_en = 1'b0;
  endtask

  // Memory responder: ack lat cycles after the request is first seen.
  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    mem_cnt        = 0;
    forever begin
      @(negedge clk);
      if (!mem_on) begin
        mem_cnt        = 0;
        bus.imem_ack   = stray;
        bus.imem_rdata = 32'hDEAD_BEEF;
      end else begin
        bus.imem_ack = 1'b0;
        if (rst || !bus.imem_req) begin
          mem_cnt = 0;
        end else begin
          mem_cnt++;
          if (mem_cnt == 1) addr_log.push_back(bus.imem_addr);
          if (mem_cnt == lat + 1) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = memword(bus.imem_addr);
            mem_cnt        = 0;
          end
        end
      end
    end
  end

  // Monitor: every accepted word must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mon_unexpected: got pc %h expected no word", bus.instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("mon_pc", bus.instr_pc, e.pc);
          check("mon_instr", bus.instruction, memword(e.pc));
          check("mon_plus8", bus.instr_pc_plus8, e.plus8);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    bus.instr_ready = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = '0;
    tick(2);

    // 1: reset values, latency, sequential stream
    check("rst_req", bus.imem_req, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", bus.instr_valid, 32'd0);
    check("rst_instr", bus.instruction, 32'hE1A0_0000);
    check("rst_pc", bus.instr_pc, 32'h0);
    push_exp(32'h0, 32'h8);
    push_exp(32'h4, 32'hC);
    push_exp(32'h8, 32'h10);
    push_exp(32'hC, 32'h14);
    bus.instr_ready = 1'b1;
    rst = 1'b0;
    check("t1_req_pre", bus.imem_req, 32'd0);
    tick(1);
    check("t1_req", bus.imem_req, 32'd1);
    check("t1_addr", bus.imem_addr, 32'h0);
    check("t1_valid_n", bus.instr_valid, 32'd0);
    tick(1);
    check("t1_valid_n1", bus.instr_valid, 32'd0);
    tick(1);
    check("t1_valid_n2", bus.instr_valid, 32'd1);
    check("t1_plus8", bus.instr_pc_plus8, 32'h8);
    wait_drain("t1", 40);
    check("t1_log0", log_at(0), 32'h0);
    check("t1_log1", log_at(1), 32'h4);
    check("t1_log2", log_at(2), 32'h8);
    check("t1_log3", log_at(3), 32'hC);

    // 2: backpressure fills buffer, then resumes
    do_reset();
    tick(12);
    check("t2_nreads", 32'(addr_log.size()), 32'd2);
    check("t2_req_off", bus.imem_req, 32'd0);
    check("t2_valid", bus.instr_valid, 32'd1);
    check("t2_head_pc", bus.instr_pc, 32'h0);
    push_exp(32'h0, 32'h8);
    push_exp(32'h4, 32'hC);
    push_exp(32'h8, 32'h10);
    bus.instr_ready = 1'b1;
    wait_drain("t2", 40);
    check("t2_resume", log_at(2), 32'h8);

    // 3: redirect during a slow read discards the old data
    lat = 3;
    do_reset();
    tick(1);
    check("t3_req", bus.imem_req, 32'd1);
    pulse_redirect(32'h0000_1002);
    check("t3_hold_req", bus.imem_req, 32'd1);
    check("t3_hold_addr", bus.imem_addr, 32'h0);
    check("t3_valid", bus.instr_valid, 32'd0);
    tick(2);
    check("t3_hold_addr2", bus.imem_addr, 32'h0);
    tick(1);
    check("t3_new_req", bus.imem_req, 32'd1);
    check("t3_new_addr", bus.imem_addr, 32'h0000_1000);
    push_exp(32'h1000, 32'h1008);
    push_exp(32'h1004, 32'h100C);
    bus.instr_ready = 1'b1;
    wait_drain("t3", 60);
    check("t3_log1", log_at(1), 32'h1000);

    // 4: redirect coinciding with an ack while buffer holds a word
    lat = 1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #2;
      if (bus.imem_ack && bus.imem_addr == 32'h4) found = 1'b1;
    end
    check("t4_ack_seen", 32'(found), 32'd1);
    check("t4_pre_valid", bus.instr_valid, 32'd1);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_2000;
    @(posedge clk);
    #1;
    bus.redirect_en = 1'b0;
    check("t4_flush_valid", bus.instr_valid, 32'd0);
    check("t4_no_discard", bus.imem_req, 32'd0);
    tick(1);
    check("t4_req", bus.imem_req, 32'd1);
    check("t4_addr", bus.imem_addr, 32'h0000_2000);
    push_exp(32'h2000, 32'h2008);
    push_exp(32'h2004, 32'h200C);
    bus.instr_ready = 1'b1;
    wait_drain("t4", 40);

    // 5: PC wrap across 2^32
    pulse_redirect(32'hFFFF_FFF8);
    push_exp(32'hFFFF_FFF8, 32'h0000_0000);
    push_exp(32'hFFFF_FFFC, 32'h0000_0004);
    push_exp(32'h0000_0000, 32'h0000_0008);
    bus.instr_ready = 1'b1;
    wait_drain("t5", 60);

    // 6: asynchronous reset mid-read, stray ack afterwards
    lat = 3;
    pulse_redirect(32'h0000_3000);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.imem_req && bus.imem_addr == 32'h3004) found = 1'b1;
      else tick(1);
    end
    check("t6_wait_seen", 32'(found), 32'd1);
    check("t6_pre_valid", bus.instr_valid, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_req", bus.imem_req, 32'd0);
    check("t6_async_addr", bus.imem_addr, 32'h0);
    check("t6_async_valid", bus.instr_valid, 32'd0);
    check("t6_async_instr", bus.instruction, 32'hE1A0_0000);
    check("t6_async_pc", bus.instr_pc, 32'h0);
    check("t6_async_plus8", bus.instr_pc_plus8, 32'h8);
    mem_on = 1'b0;
    tick(2);
    addr_log.delete();
    rst   = 1'b0;
    stray = 1'b1;
    tick(1);
    stray = 1'b0;
    check("t6_req", bus.imem_req, 32'd1);
    check("t6_addr", bus.imem_addr, 32'h0);
    check("t6_valid", bus.instr_valid, 32'd0);
    lat = 1;
    push_exp(32'h0, 32'h8);
    push_exp(32'h4, 32'hC);
    mem_on = 1'b1;
    bus.instr_ready = 1'b1;
    wait_drain("t6", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
